// File: rtl/rrf.sv
// Retirement register file: committed arch->phys map updated by ROB retires,
// returns the displaced physical register one cycle later, feeds RAT recovery.
package rrf_pkg;
    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned NUM_PHYS = 64;
    localparam int unsigned PHYS_W   = $clog2(NUM_PHYS);
    localparam int unsigned ARCH_W   = $clog2(NUM_ARCH);

    typedef struct packed {
        logic              monitor_regf_we;
        logic [ARCH_W-1:0] monitor_rd_addr;
    } rvfi_t;

    typedef struct packed {
        logic [PHYS_W-1:0] pd;
        rvfi_t             rvfi;
    } rob_entry_t;
endpackage

module rrf
    import rrf_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dequeue_valid,
    input  rob_entry_t                        rob_out,
    input  logic                              flush,
    output logic                              free_valid,
    output logic [PHYS_W-1:0]                 free_preg,
    output logic [NUM_ARCH-1:0][PHYS_W-1:0]   rrf_map,
    output logic                              restore_valid,
    output logic [31:0]                       retire_count
);

    logic [NUM_ARCH-1:0][PHYS_W-1:0] map_q, map_d;
    logic                            free_valid_q, free_valid_d;
    logic [PHYS_W-1:0]               free_preg_q, free_preg_d;
    logic [31:0]                     retire_count_q, retire_count_d;

    logic              wr;
    logic [ARCH_W-1:0] rd;
    logic [PHYS_W-1:0] pd;
    logic [PHYS_W-1:0] old_pd;

    assign rd     = rob_out.rvfi.monitor_rd_addr;
    assign pd     = rob_out.pd;
    assign wr     = dequeue_valid && rob_out.rvfi.monitor_regf_we && (rd != '0);
    assign old_pd = map_q[rd];

    always_comb begin
        map_d          = map_q;
        free_valid_d   = 1'b0;
        free_preg_d    = free_preg_q;
        retire_count_d = retire_count_q;
        if (wr) begin
            map_d[rd]      = pd;
            // Rewriting the same tag would free a register that is still live.
            free_valid_d   = (old_pd != pd);
            free_preg_d    = old_pd;
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_comb begin
        rrf_map = map_q;
        if (wr) begin
            rrf_map[rd] = pd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ARCH); i++) begin
                map_q[i] <= PHYS_W'(i);
            end
            free_valid_q   <= 1'b0;
            free_preg_q    <= '0;
            retire_count_q <= '0;
        end else begin
            map_q          <= map_d;
            free_valid_q   <= free_valid_d;
            free_preg_q    <= free_preg_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign free_valid    = free_valid_q;
    assign free_preg     = free_preg_q;
    assign retire_count  = retire_count_q;
    assign restore_valid = flush && !rst;

endmodule

// File: tb/tb_rrf.sv
// Self-checking bench for rrf: per-cycle reference model compare plus
// hand-computed directed expectations.
module tb_rrf;
    import rrf_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            dequeue_valid;
    rob_entry_t                      rob_out;
    logic                            flush;
    logic                            free_valid;
    logic [PHYS_W-1:0]               free_preg;
    logic [NUM_ARCH-1:0][PHYS_W-1:0] rrf_map;
    logic                            restore_valid;
    logic [31:0]                     retire_count;

    int tests  = 0;
    int failed = 0;
    bit check_en = 1'b0;

    rrf dut (
        .clk           (clk),
        .rst           (rst),
        .dequeue_valid (dequeue_valid),
        .rob_out       (rob_out),
        .flush         (flush),
        .free_valid    (free_valid),
        .free_preg     (free_preg),
        .rrf_map       (rrf_map),
        .restore_valid (restore_valid),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    // Reference model: committed table as a plain integer array.
    int          m_map [NUM_ARCH];
    bit          m_fv;
    int          m_fp;
    int unsigned m_cnt;

    function automatic bit cur_write();
        return dequeue_valid && rob_out.rvfi.monitor_regf_we && (rob_out.rvfi.monitor_rd_addr != 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH; i++) m_map[i] <= i;
            m_fv  <= 1'b0;
            m_fp  <= 0;
            m_cnt <= 0;
        end else if (cur_write()) begin
            m_map[rob_out.rvfi.monitor_rd_addr] <= int'(rob_out.pd);
            m_fv  <= (m_map[rob_out.rvfi.monitor_rd_addr] != int'(rob_out.pd));
            m_fp  <= m_map[rob_out.rvfi.monitor_rd_addr];
            m_cnt <= m_cnt + 1;
        end else begin
            m_fv <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            int exp_map;
            bit mism;
            chk("model free_valid", 32'(free_valid), 32'(m_fv));
            if (m_fv) chk("model free_preg", 32'(free_preg), 32'(m_fp));
            chk("model retire_count", retire_count, m_cnt);
            chk("model restore_valid", 32'(restore_valid), 32'(flush && !rst));
            mism = 1'b0;
            for (int j = 0; j < NUM_ARCH; j++) begin
                exp_map = (cur_write() && rob_out.rvfi.monitor_rd_addr == j) ?
                          int'(rob_out.pd) : m_map[j];
                if (int'(rrf_map[j]) != exp_map && !mism) begin
                    mism = 1'b1;
                    chk($sformatf("model rrf_map[%0d]", j), 32'(rrf_map[j]), 32'(exp_map));
                end
            end
            if (!mism) tests++;
        end
    end

    task automatic drive(input bit dv, input int rd, input bit we, input int pd,
                         input bit fl, input bit r);
        @(posedge clk);
        #1;
        dequeue_valid                   = dv;
        rob_out.rvfi.monitor_rd_addr    = ARCH_W'(rd);
        rob_out.rvfi.monitor_regf_we    = we;
        rob_out.pd                      = PHYS_W'(pd);
        flush                           = fl;
        rst                             = r;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit ident;
        rst = 1'b1;
        dequeue_valid = 1'b0;
        rob_out = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        @(negedge clk);
        ident = 1'b1;
        for (int i = 0; i < NUM_ARCH; i++) if (int'(rrf_map[i]) != i) ident = 1'b0;
        chk("reset identity map", 32'(ident), 32'd1);
        chk("reset free_valid", 32'(free_valid), 32'd0);
        chk("reset retire_count", retire_count, 32'd0);

        // Single writing retire
        drive(1'b1, 5, 1'b1, 40, 1'b0, 1'b0);
        @(negedge clk);
        chk("bypass map[5]", 32'(rrf_map[5]), 32'd40);
        idle();
        @(negedge clk);
        chk("free after rd5 valid", 32'(free_valid), 32'd1);
        chk("free after rd5 preg", 32'(free_preg), 32'd5);
        chk("map[5] committed", 32'(rrf_map[5]), 32'd40);
        chk("count after rd5", retire_count, 32'd1);

        // Back-to-back same rd
        drive(1'b1, 7, 1'b1, 33, 1'b0, 1'b0);
        drive(1'b1, 7, 1'b1, 50, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b first free", 32'(free_preg), 32'd7);
        idle();
        @(negedge clk);
        chk("b2b second free valid", 32'(free_valid), 32'd1);
        chk("b2b second free", 32'(free_preg), 32'd33);
        chk("b2b map[7]", 32'(rrf_map[7]), 32'd50);
        idle();
        @(negedge clk);
        chk("b2b no third free", 32'(free_valid), 32'd0);

        // Non-writing retires
        drive(1'b1, 0, 1'b1, 12, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0 bypass stays 0", 32'(rrf_map[0]), 32'd0);
        drive(1'b1, 9, 1'b0, 20, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0 no free", 32'(free_valid), 32'd0);
        idle();
        @(negedge clk);
        chk("we0 no free", 32'(free_valid), 32'd0);
        chk("we0 map[9]", 32'(rrf_map[9]), 32'd9);
        chk("non-writing count", retire_count, 32'd3);

        // Flush with same-cycle retire
        drive(1'b1, 3, 1'b1, 44, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush restore_valid", 32'(restore_valid), 32'd1);
        chk("flush bypass map[3]", 32'(rrf_map[3]), 32'd44);
        idle();
        @(negedge clk);
        chk("flush free preg", 32'(free_preg), 32'd3);
        chk("flush restore drops", 32'(restore_valid), 32'd0);

        // Degenerate pd == old map
        drive(1'b1, 5, 1'b1, 40, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("degenerate no free", 32'(free_valid), 32'd0);
        chk("degenerate count", retire_count, 32'd5);

        // Reset mid-operation with pending free and a presented retire
        drive(1'b1, 10, 1'b1, 60, 1'b0, 1'b0);
        drive(1'b1, 11, 1'b1, 61, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst pending free", 32'(free_valid), 32'd1);
        chk("rst blocks restore", 32'(restore_valid), 32'd0);
        idle();
        @(negedge clk);
        ident = 1'b1;
        for (int i = 0; i < NUM_ARCH; i++) if (int'(rrf_map[i]) != i) ident = 1'b0;
        chk("post-rst identity", 32'(ident), 32'd1);
        chk("post-rst free_valid", 32'(free_valid), 32'd0);
        chk("post-rst count", retire_count, 32'd0);

        // Deterministic mixed traffic, checked by the model
        for (int i = 0; i < 60; i++) begin
            drive((i % 7) != 3, (i * 7) % 32, (i % 5) != 0, (i * 13 + 5) % 64,
                  (i % 6) == 0, 1'b0);
        end
        idle();
        @(negedge clk);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
